// File: rtl/filt_pkg.sv
// Shared definitions for the debounce filter and its neighbours.
// Holds the pulse_meter state encoding, default counter width and record field widths.
package filt_pkg;
    typedef enum logic [1:0] {
        PM_IDLE = 2'd0,
        PM_SKIP = 2'd1,
        PM_RUN  = 2'd2
    } pm_state_e;

    localparam int PM_CW_DEF = 16;
    localparam int PM_LVL_W  = 1;
    localparam int PM_SAT_W  = 1;

    // Record layout is {level, len, sat}.
    function automatic int pm_rec_w(input int cw);
        return cw + PM_LVL_W + PM_SAT_W;
    endfunction
endpackage

// File: rtl/pulse_meter_obuf.sv
// Single-entry valid/ready output register; a record arriving while full and
// not being accepted is dropped and flagged in a sticky overflow bit.
module pulse_meter_obuf #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    input  logic         o_ready,
    input  logic         clr_ovf,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_ovf
);
    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_ovf;
    logic         w_free;
    logic         w_drop;

    assign w_free = !r_valid || o_ready;
    assign w_drop = i_vld && !w_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (i_vld && w_free) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (o_ready) begin
                r_valid <= 1'b0;
            end
            // a drop in the same cycle as a clear keeps the flag set
            r_ovf <= w_drop | (r_ovf & ~clr_ovf);
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ovf   = r_ovf;
endmodule

// File: rtl/pulse_meter.sv
// Measures each completed high/low period of the filtered level in en ticks and
// hands it off as a {level, len, sat} record through a single-entry output register.
module pulse_meter
    import filt_pkg::*;
#(
    parameter int CW = PM_CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          i,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          o_level,
    output logic [CW-1:0] o_len,
    output logic          o_sat,
    output logic          o_ovf,
    input  logic          clr_ovf
);
    localparam int            RW   = pm_rec_w(CW);
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    pm_state_e     r_state;
    pm_state_e     w_state_nxt;
    logic          r_lvl;
    logic          r_sat;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_edge;
    logic          w_rec_vld;
    logic [RW-1:0] w_rec;
    logic [RW-1:0] w_obuf_data;

    assign w_edge = (r_state != PM_IDLE) && (i != r_lvl);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= PM_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rec_vld   = 1'b0;
        case (r_state)
            PM_IDLE: w_state_nxt = PM_SKIP;
            PM_SKIP: if (w_edge) w_state_nxt = PM_RUN;
            PM_RUN:  w_rec_vld = w_edge;
            default: w_state_nxt = PM_IDLE;
        endcase
    end

    // The edge cycle's own tick belongs to the period that starts there.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_edge)
            w_cnt_nxt = {{(CW-1){1'b0}}, en};
        else if (en && (r_cnt != CMAX))
            w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lvl <= 1'b0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (r_state == PM_IDLE) begin
            r_lvl <= i;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_lvl <= i;
            r_cnt <= w_cnt_nxt;
            r_sat <= (w_cnt_nxt == CMAX) | (r_sat & ~w_edge);
        end
    end

    assign w_rec = {r_lvl, r_cnt, r_sat};

    pulse_meter_obuf #(.W(RW)) u_obuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (w_rec_vld),
        .i_data  (w_rec),
        .o_ready (o_ready),
        .clr_ovf (clr_ovf),
        .o_valid (o_valid),
        .o_data  (w_obuf_data),
        .o_ovf   (o_ovf)
    );

    assign {o_level, o_len, o_sat} = w_obuf_data;
endmodule
